// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg
// Shared types for the pipeline boundary registers: skid state encoding,
// default bundle widths, saturation limit and the core control bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int c_CTRL_W_DEFAULT = 8;
    localparam int c_DATA_W_DEFAULT = 64;
    localparam logic [31:0] c_SAT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Control bundle carried between core stages; packs into c_CTRL_W_DEFAULT bits.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       branch;
    } core_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_ctr.sv
// ============================================================================
// pipe_sat_ctr
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_sat_ctr
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 32'd0;
        end else if (i_inc && (r_count != c_SAT_MAX)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// pipe_stage_skid
// Valid/ready pipeline boundary register with a 2-entry skid buffer, flush and
// bubble kill mask on control bits. Optional perf counters: PIPE_STAGE_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                CTRL_W    = c_CTRL_W_DEFAULT,
    parameter int                DATA_W    = c_DATA_W_DEFAULT,
    parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
`endif
);

    skid_state_e       r_state;
    skid_state_e       w_next;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_accept;
    logic w_emit;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_accept = i_in_valid & r_in_ready;
    assign w_emit   = o_out_valid & i_out_ready;

    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next         = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && !w_emit) begin
                    w_next      = FULL;
                    w_load_skid = 1'b1;
                end else if (w_emit && !w_accept) begin
                    w_next = EMPTY;
                end else if (w_accept && w_emit) begin
                    w_load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (w_emit) begin
                    w_next           = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
        // Flush discards everything resident, including a beat arriving this cycle.
        if (i_flush) begin
            w_next           = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != FULL);
            if (w_load_main_in) begin
                r_main_ctrl <= i_in_ctrl;
                r_main_data <= i_in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= i_in_ctrl;
                r_skid_data <= i_in_data;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = (r_state != EMPTY);
    // Side-effecting control bits read as zero in bubbles; data keeps its last value.
    assign o_out_ctrl  = o_out_valid ? r_main_ctrl : (r_main_ctrl & ~KILL_MASK);
    assign o_out_data  = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_ctr u_stall_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (o_out_valid & ~i_out_ready),
        .o_count (o_stall_cnt)
    );

    pipe_sat_ctr u_flush_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (i_flush & (r_state != EMPTY)),
        .o_count (o_flush_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// tb_pipe_stage_skid
// Directed self-checking bench for pipe_stage_skid (KILL_MASK = 8'h05).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        i_flush;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [7:0]  i_in_ctrl;
    logic [63:0] i_in_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [7:0]  o_out_ctrl;
    logic [63:0] o_out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] o_stall_cnt;
    logic [31:0] o_flush_cnt;
`endif

    int total;
    int bad;

    pipe_stage_skid #(
        .CTRL_W    (8),
        .DATA_W    (64),
        .KILL_MASK (8'h05)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_ctrl   (i_in_ctrl),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_ctrl  (o_out_ctrl),
        .o_out_data  (o_out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .o_stall_cnt (o_stall_cnt),
        .o_flush_cnt (o_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [63:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl);
        i_in_valid  = v;
        i_in_data   = d;
        i_in_ctrl   = c;
        i_out_ready = ordy;
        i_flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] c,
                           input logic [63:0] d, input logic rdy);
        chk({tag, ".valid"}, {63'd0, o_out_valid}, {63'd0, v});
        chk({tag, ".ctrl"},  {56'd0, o_out_ctrl},  {56'd0, c});
        chk({tag, ".data"},  o_out_data, d);
        chk({tag, ".ready"}, {63'd0, o_in_ready},  {63'd0, rdy});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;

        // Reset with upstream valid asserted: nothing may be captured.
        step(1'b1, 64'hAA, 8'hFF, 1'b1, 1'b0);
        chk_out("rst1", 1'b0, 8'h00, 64'h0, 1'b1);
        step(1'b1, 64'hAA, 8'hFF, 1'b1, 1'b0);
        chk_out("rst2", 1'b0, 8'h00, 64'h0, 1'b1);

        // First accept on the first edge after reset release.
        rst = 1'b0;
        step(1'b1, 64'h11, 8'h03, 1'b1, 1'b0);
        chk_out("first", 1'b1, 8'h03, 64'h11, 1'b1);
        // Bubble: ctrl 03 with mask 05 -> 02, data held.
        step(1'b0, 64'h99, 8'hFF, 1'b1, 1'b0);
        chk_out("bubble", 1'b0, 8'h02, 64'h11, 1'b1);

        // Streaming 1..8 with no gaps.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 8'(i), 1'b1, 1'b0);
            chk_out($sformatf("stream%0d", i), 1'b1, 8'(i), 64'(i), 1'b1);
        end
        step(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        chk_out("stream_end", 1'b0, 8'h08 & 8'hFA, 64'h8, 1'b1);

        // Back-pressure: out_ready low for three cycles, source holds beat 3.
        step(1'b1, 64'h1, 8'h10, 1'b1, 1'b0);
        chk_out("bp1", 1'b1, 8'h10, 64'h1, 1'b1);
        step(1'b1, 64'h2, 8'h20, 1'b0, 1'b0);
        chk_out("bp2", 1'b1, 8'h10, 64'h1, 1'b0);
        step(1'b1, 64'h3, 8'h30, 1'b0, 1'b0);
        chk_out("bp3", 1'b1, 8'h10, 64'h1, 1'b0);
        step(1'b1, 64'h3, 8'h30, 1'b0, 1'b0);
        chk_out("bp4", 1'b1, 8'h10, 64'h1, 1'b0);
        step(1'b1, 64'h3, 8'h30, 1'b1, 1'b0);
        chk_out("bp5", 1'b1, 8'h20, 64'h2, 1'b1);
        step(1'b1, 64'h3, 8'h30, 1'b1, 1'b0);
        chk_out("bp6", 1'b1, 8'h30, 64'h3, 1'b1);
        step(1'b1, 64'h4, 8'h40, 1'b1, 1'b0);
        chk_out("bp7", 1'b1, 8'h40, 64'h4, 1'b1);
        step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        chk_out("bp8", 1'b0, 8'h40, 64'h4, 1'b1);

        // Flush while FULL with all-ones ctrl resident.
        step(1'b1, 64'hA1, 8'hFF, 1'b0, 1'b0);
        chk_out("fl_one", 1'b1, 8'hFF, 64'hA1, 1'b1);
        step(1'b1, 64'hA2, 8'hFF, 1'b0, 1'b0);
        chk_out("fl_full", 1'b1, 8'hFF, 64'hA1, 1'b0);
        step(1'b0, 64'h0, 8'h00, 1'b0, 1'b1);
        chk_out("fl_kill", 1'b0, 8'hFA, 64'hA1, 1'b1);
        step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        chk_out("fl_idle", 1'b0, 8'hFA, 64'hA1, 1'b1);

        // Accept + emit + flush in ONE: incoming beat must never surface.
        step(1'b1, 64'hB1, 8'h01, 1'b1, 1'b0);
        chk_out("ae_one", 1'b1, 8'h01, 64'hB1, 1'b1);
        step(1'b1, 64'hB2, 8'h04, 1'b1, 1'b1);
        chk_out("ae_flush", 1'b0, 8'h00, 64'hB1, 1'b1);
        step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        chk_out("ae_after", 1'b0, 8'h00, 64'hB1, 1'b1);

        // Flush in EMPTY is a no-op.
        step(1'b0, 64'h0, 8'h00, 1'b1, 1'b1);
        chk_out("fl_empty", 1'b0, 8'h00, 64'hB1, 1'b1);

        // Reset mid-stream drops a resident beat and clears outputs.
        step(1'b1, 64'hC0, 8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        chk_out("rst_mid", 1'b0, 8'h00, 64'h0, 1'b1);
        rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        chk("perf_rst_stall", {32'd0, o_stall_cnt}, 64'd0);
        chk("perf_rst_flush", {32'd0, o_flush_cnt}, 64'd0);
        step(1'b1, 64'hC1, 8'h01, 1'b0, 1'b0);
        step(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        chk("perf_stall3", {32'd0, o_stall_cnt}, 64'd3);
        step(1'b0, 64'h0, 8'h00, 1'b1, 1'b1);
        chk("perf_stall_hold", {32'd0, o_stall_cnt}, 64'd3);
        chk("perf_flush1", {32'd0, o_flush_cnt}, 64'd1);
        rst = 1'b1;
        step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        chk("perf_clr_stall", {32'd0, o_stall_cnt}, 64'd0);
        chk("perf_clr_flush", {32'd0, o_flush_cnt}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
